deadlock_idx0_monitor: RTL and testbench



---
 rtl/deadlock_monitor_pkg.sv | 33 +++
 rtl/deadlock_persist_counter.sv | 47 ++++
 rtl/deadlock_idx0_monitor.sv | 78 +++++++
 tb/tb_deadlock_idx0_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/deadlock_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : deadlock_monitor_pkg
//  Description : Shared defaults and helpers for the dataflow deadlock
//                monitor (process counts, detection window, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package deadlock_monitor_pkg;

    // Default geometry of the idx0 dataflow region
    localparam int C_NUM_AXIS      = 5;
    localparam int C_NUM_IDLE      = 14;
    localparam int C_NUM_PROC      = 5;
    localparam int C_DETECT_CYCLES = 16;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage : deadlock_monitor_pkg
`default_nettype wire

// File: rtl/deadlock_persist_counter.sv
`default_nettype none
// ============================================================================
//  Module      : deadlock_persist_counter
//  Description : Saturating persistence counter. Counts consecutive cycles
//                with cond=1, clears on any cond=0 cycle, and flags `hit`
//                when the current edge completes (or extends) a run of
//                DETECT_CYCLES qualifying samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module deadlock_persist_counter
    import deadlock_monitor_pkg::*;
#(
    parameter int DETECT_CYCLES = C_DETECT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic cond,
    output logic hit
);

    localparam int CNT_W = clog2(DETECT_CYCLES + 1);

    // Saturation point and the value reached one edge before it
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DETECT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DETECT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive qualifying cycles; any break restarts from zero
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (!cond) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt==PRE with cond=1 means this edge is the DETECT_CYCLES-th sample;
    // cnt==MAX keeps the flag up while the condition persists
    always_comb begin
        hit = (cond && (cnt == CNT_PRE)) || (cond && (cnt == CNT_MAX));
    end

endmodule : deadlock_persist_counter
`default_nettype wire

// File: rtl/deadlock_idx0_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : deadlock_idx0_monitor
//  Description : Deadlock detector for dataflow region idx0. Raises `block`
//                once every top-level process has been idle or blocked,
//                with at least one blocked and no external AXIS stall, for
//                DETECT_CYCLES consecutive cycles.
//  Config      : DEADLOCK_MONITOR_STICKY_EN - when defined, `block` latches
//                high until reset; otherwise it follows the detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module deadlock_idx0_monitor
    import deadlock_monitor_pkg::*;
#(
    parameter int NUM_AXIS      = C_NUM_AXIS,
    parameter int NUM_IDLE      = C_NUM_IDLE,
    parameter int NUM_PROC      = C_NUM_PROC,
    parameter int DETECT_CYCLES = C_DETECT_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_IDLE-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    output logic                block
);

    logic [NUM_PROC-1:0] stuck;
    logic                cond;
    logic                hit;

    // A process is stuck when it is idle or blocked. The kernel is only
    // deadlocked if all are stuck, someone is actually blocked (otherwise it
    // is just idle) and the testbench is not starving any AXIS port.
    always_comb begin
        stuck = inst_idle_sigs[NUM_PROC-1:0] | inst_block_sigs;
        cond  = (&stuck) && (|inst_block_sigs) && !(|axis_block_sigs);
    end

    // Sub-instance idle bits are informational only and never qualify cond
    generate
        if (NUM_IDLE > NUM_PROC) begin : g_info_idle
            logic unused_info_idle;
            assign unused_info_idle = &{1'b0, inst_idle_sigs[NUM_IDLE-1:NUM_PROC]};
        end
    endgenerate

    deadlock_persist_counter #(
        .DETECT_CYCLES (DETECT_CYCLES)
    ) u_persist_counter (
        .clock (clock),
        .reset (reset),
        .cond  (cond),
        .hit   (hit)
    );

`ifdef DEADLOCK_MONITOR_STICKY_EN
    // Latch the deadlock flag; only reset clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            block <= 1'b0;
        end else begin
            block <= block | hit;
        end
    end
`else
    // Follow the detector; drops one edge after the condition breaks
    always_ff @(posedge clock) begin
        if (reset) begin
            block <= 1'b0;
        end else begin
            block <= hit;
        end
    end
`endif

endmodule : deadlock_idx0_monitor
`default_nettype wire

// File: tb/tb_deadlock_idx0_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_deadlock_idx0_monitor
//  Description : Directed self-checking bench for deadlock_idx0_monitor
//                (DETECT_CYCLES=16, NUM_PROC=5). Honours
//                DEADLOCK_MONITOR_STICKY_EN for the release scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deadlock_idx0_monitor;

    localparam int NUM_AXIS      = 5;
    localparam int NUM_IDLE      = 14;
    localparam int NUM_PROC      = 5;
    localparam int DETECT_CYCLES = 16;

    logic                clock;
    logic                reset;
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_IDLE-1:0] inst_idle_sigs;
    logic [NUM_PROC-1:0] inst_block_sigs;
    logic                block;

    int n_tests;
    int n_fail;

    deadlock_idx0_monitor #(
        .NUM_AXIS      (NUM_AXIS),
        .NUM_IDLE      (NUM_IDLE),
        .NUM_PROC      (NUM_PROC),
        .DETECT_CYCLES (DETECT_CYCLES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: block=%b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one active edge; inputs changed after return apply to the next edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Deadlock pattern: P1..P3 idle, P0 and P4 blocked, no AXIS stall
    task automatic drive_deadlock();
        inst_idle_sigs  = 14'b0;
        inst_idle_sigs[NUM_PROC-1:0] = 5'b01110;
        inst_block_sigs = 5'b10001;
        axis_block_sigs = 5'b00000;
    endtask

    // Plainly idle kernel: everyone idle, nobody blocked
    task automatic drive_idle();
        inst_idle_sigs  = 14'b0;
        inst_idle_sigs[NUM_PROC-1:0] = 5'b11111;
        inst_block_sigs = 5'b00000;
        axis_block_sigs = 5'b00000;
    endtask

    // One reset edge with deadlock inputs present; reset must win
    task automatic do_reset(input string tag);
        reset = 1'b1;
        drive_deadlock();
        tick();
        check(tag, block, 1'b0);
        reset = 1'b0;
    endtask

    // With cond already driven to 1: edges 1..15 low, edge 16 high
    task automatic expect_rise(input string tag);
        for (int i = 1; i < DETECT_CYCLES; i++) begin
            tick();
            check({tag, "_pre"}, block, 1'b0);
        end
        tick();
        check({tag, "_rise"}, block, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held 3 cycles with random inputs
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            axis_block_sigs = NUM_AXIS'($urandom);
            inst_idle_sigs  = NUM_IDLE'($urandom);
            inst_block_sigs = NUM_PROC'($urandom);
            tick();
            check("reset_hold", block, 1'b0);
        end
        reset = 1'b0;

        // Idle kernel is not a deadlock
        drive_idle();
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_only", block, 1'b0);
        end

        // Basic deadlock, then hold well past saturation
        drive_deadlock();
        expect_rise("basic");
        for (int i = 0; i < 30; i++) begin
            tick();
            check("hold_sat", block, 1'b1);
        end

        // Condition breaks
        drive_idle();
        tick();
`ifdef DEADLOCK_MONITOR_STICKY_EN
        check("sticky_keep", block, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("sticky_keep", block, 1'b1);
        end
        reset = 1'b1;
        tick();
        check("sticky_reset", block, 1'b0);
        reset = 1'b0;
`else
        check("release_drop", block, 1'b0);
        tick();
        check("release_stay", block, 1'b0);
`endif

        // External AXIS stall masks the deadlock; release starts the window
        do_reset("rst_axis");
        drive_deadlock();
        axis_block_sigs = 5'b00100;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("axis_stall", block, 1'b0);
        end
        axis_block_sigs = 5'b00000;
        expect_rise("axis_release");

        // 15 good edges, one break, then full window again
        do_reset("rst_glitch");
        drive_deadlock();
        for (int i = 0; i < DETECT_CYCLES - 1; i++) begin
            tick();
            check("glitch_pre", block, 1'b0);
        end
        drive_idle();
        tick();
        check("glitch_break", block, 1'b0);
        drive_deadlock();
        expect_rise("glitch_resume");

        // Reset while block=1 clears it
        reset = 1'b1;
        tick();
        check("reset_on_block", block, 1'b0);
        reset = 1'b0;

        // Reset mid-count discards partial progress
        drive_deadlock();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midcnt_pre", block, 1'b0);
        end
        do_reset("midcnt_reset");
        drive_deadlock();
        expect_rise("midcnt_after");

        // One process neither idle nor blocked: no deadlock
        do_reset("rst_partial");
        inst_idle_sigs  = 14'b0;
        inst_idle_sigs[NUM_PROC-1:0] = 5'b01110;
        inst_block_sigs = 5'b10000;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("proc0_running", block, 1'b0);
        end

        // Sub-instance idle bits toggling must not disturb detection
        do_reset("rst_info");
        drive_deadlock();
        for (int i = 1; i < DETECT_CYCLES; i++) begin
            inst_idle_sigs[NUM_IDLE-1:NUM_PROC] = (NUM_IDLE-NUM_PROC)'($urandom);
            tick();
            check("info_pre", block, 1'b0);
        end
        inst_idle_sigs[NUM_IDLE-1:NUM_PROC] = (NUM_IDLE-NUM_PROC)'($urandom);
        tick();
        check("info_rise", block, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_deadlock_idx0_monitor
`default_nettype wire
